// File: rtl/mips_cpu_pkg.sv
// Shared constants for the MIPS CPU execute stage: ALU operation classes,
// internal ALU control codes, and the opcode/function encodings it decodes.
package mips_cpu_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE = 2'b11;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_XOR  = 4'b0011,
      ALU_NOR  = 4'b0100,
      ALU_SUB  = 4'b0110,
      ALU_SLT  = 4'b0111,
      ALU_SLL  = 4'b1000,
      ALU_SRL  = 4'b1001,
      ALU_SRA  = 4'b1010,
      ALU_MULT = 4'b1011,
      ALU_DIV  = 4'b1100,
      ALU_LUI  = 4'b1101,
      ALU_MTHI = 4'b1110,
      ALU_MTLO = 4'b1111
   } alucon_t;

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_SLTIU  = 6'b001011;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_LUI    = 6'b001111;

   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;
   localparam logic [5:0] FN_SLLV  = 6'b000100;
   localparam logic [5:0] FN_SRLV  = 6'b000110;
   localparam logic [5:0] FN_SRAV  = 6'b000111;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;

endpackage

// File: rtl/mips_cpu_exec_alu_decode.sv
// ALU control decode: maps the control unit's aluop class plus the
// instruction's func/opcode fields onto an internal ALU operation code.
module mips_cpu_exec_alu_decode
   import mips_cpu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] func,
   input  logic [5:0] insop,
   output logic [3:0] alucon
);

   alucon_t code;

   always_comb begin
      code = ALU_ADD;
      case (aluop)
         ALUOP_ADD: code = ALU_ADD;
         ALUOP_SUB: code = ALU_SUB;
         ALUOP_RTYPE: begin
            // JR, JALR, MFHI and MFLO fall through to ADD
            case (func)
               FN_ADD,  FN_ADDU:  code = ALU_ADD;
               FN_SUB,  FN_SUBU:  code = ALU_SUB;
               FN_AND:            code = ALU_AND;
               FN_OR:             code = ALU_OR;
               FN_XOR:            code = ALU_XOR;
               FN_NOR:            code = ALU_NOR;
               FN_SLT,  FN_SLTU:  code = ALU_SLT;
               FN_SLL,  FN_SLLV:  code = ALU_SLL;
               FN_SRL,  FN_SRLV:  code = ALU_SRL;
               FN_SRA,  FN_SRAV:  code = ALU_SRA;
               FN_MULT, FN_MULTU: code = ALU_MULT;
               FN_DIV,  FN_DIVU:  code = ALU_DIV;
               FN_MTHI:           code = ALU_MTHI;
               FN_MTLO:           code = ALU_MTLO;
               default:           code = ALU_ADD;
            endcase
         end
         default: begin
            case (insop)
               OP_ADDI, OP_ADDIU: code = ALU_ADD;
               OP_SLTI, OP_SLTIU: code = ALU_SLT;
               OP_ANDI:           code = ALU_AND;
               OP_ORI:            code = ALU_OR;
               OP_XORI:           code = ALU_XOR;
               OP_LUI:            code = ALU_LUI;
               default:           code = ALU_ADD;
            endcase
         end
      endcase
   end

   assign alucon = code;

endmodule

// File: rtl/mips_cpu_exec_unit.sv
// Execute stage of the single-cycle MIPS CPU: branch-operand select, 32-bit
// ALU with eq/lt flags, and the HI/LO registers written by mult/div/mthi/mtlo.
module mips_cpu_exec_unit
   import mips_cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic [5:0]  insop,
   input  logic [5:0]  func,
   input  logic [1:0]  aluop,
   input  logic        unsign,
   input  logic        alusrc,
   input  logic [31:0] alu_a,
   input  logic [31:0] rt_data,
   input  logic [31:0] imm,
   output logic [31:0] result,
   output logic        eq,
   output logic        lt,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   logic [3:0]  alucon_bits;
   alucon_t     alucon;
   logic [31:0] b_imm;
   logic [31:0] b;
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] product;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;

   mips_cpu_exec_alu_decode u_decode (
      .aluop  (aluop),
      .func   (func),
      .insop  (insop),
      .alucon (alucon_bits)
   );

   assign alucon = alucon_t'(alucon_bits);

   // REGIMM/BLEZ/BGTZ compare rs against zero rather than the immediate
   assign b_imm = (insop == OP_REGIMM || insop == OP_BLEZ || insop == OP_BGTZ) ? 32'h0 : imm;
   assign b     = alusrc ? b_imm : rt_data;

   assign eq = (alu_a == b);
   assign lt = unsign ? (alu_a < b) : ($signed(alu_a) < $signed(b));

   // Extending to 64 bits first makes one multiplier serve both signednesses
   assign a_ext   = unsign ? {32'h0, alu_a} : {{32{alu_a[31]}}, alu_a};
   assign b_ext   = unsign ? {32'h0, b} : {{32{b[31]}}, b};
   assign product = a_ext * b_ext;

   // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0
   assign a_neg     = !unsign && alu_a[31];
   assign b_neg     = !unsign && b[31];
   assign a_mag     = a_neg ? (32'h0 - alu_a) : alu_a;
   assign b_mag     = b_neg ? (32'h0 - b) : b;
   assign q_mag     = (b_mag == 32'h0) ? 32'h0 : a_mag / b_mag;
   assign r_mag     = (b_mag == 32'h0) ? 32'h0 : a_mag % b_mag;
   assign quotient  = (a_neg ^ b_neg) ? (32'h0 - q_mag) : q_mag;
   assign remainder = a_neg ? (32'h0 - r_mag) : r_mag;

   always_comb begin
      result = 32'h0;
      case (alucon)
         ALU_AND: result = alu_a & b;
         ALU_OR:  result = alu_a | b;
         ALU_ADD: result = alu_a + b;
         ALU_XOR: result = alu_a ^ b;
         ALU_NOR: result = ~(alu_a | b);
         ALU_SUB: result = alu_a - b;
         ALU_SLT: result = {31'h0, lt};
         ALU_SLL: result = b << alu_a[4:0];
         ALU_SRL: result = b >> alu_a[4:0];
         ALU_SRA: result = $signed(b) >>> alu_a[4:0];
         ALU_LUI: result = {b[15:0], 16'h0};
         default: result = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_reg <= 32'h0;
         lo_reg <= 32'h0;
      end else if (clk_enable) begin
         case (alucon)
            ALU_MULT: begin
               hi_reg <= product[63:32];
               lo_reg <= product[31:0];
            end
            ALU_DIV: begin
               if (b != 32'h0) begin
                  hi_reg <= remainder;
                  lo_reg <= quotient;
               end
            end
            ALU_MTHI: hi_reg <= alu_a;
            ALU_MTLO: lo_reg <= alu_a;
            default: ;
         endcase
      end
   end

   assign hi = hi_reg;
   assign lo = lo_reg;

endmodule

// File: tb/tb_mips_cpu_exec_unit.sv
// Directed self-checking bench for the MIPS execute stage: ALU results,
// flags, branch operand selection and HI/LO register behaviour.
module tb_mips_cpu_exec_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_enable;
   logic [5:0]  insop;
   logic [5:0]  func;
   logic [1:0]  aluop;
   logic        unsign;
   logic        alusrc;
   logic [31:0] alu_a;
   logic [31:0] rt_data;
   logic [31:0] imm;
   logic [31:0] result;
   logic        eq;
   logic        lt;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   mips_cpu_exec_unit dut (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .insop      (insop),
      .func       (func),
      .aluop      (aluop),
      .unsign     (unsign),
      .alusrc     (alusrc),
      .alu_a      (alu_a),
      .rt_data    (rt_data),
      .imm        (imm),
      .result     (result),
      .eq         (eq),
      .lt         (lt),
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
      end
      $display("check %-12s observed=%08h expected=%08h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [5:0] iop,
                        input logic uns, input logic src, input logic [31:0] a,
                        input logic [31:0] rt, input logic [31:0] im);
      aluop   = op;
      func    = fn;
      insop   = iop;
      unsign  = uns;
      alusrc  = src;
      alu_a   = a;
      rt_data = rt;
      imm     = im;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      clk_enable = 1'b1;
      drive(2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick();
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      reset = 1'b0;

      // ADDU wraps into the sign bit
      drive(2'b10, 6'b100001, 6'd0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h0);
      check("addu", result, 32'h80000000);
      check("addu_eq", {31'h0, eq}, 32'h0);

      drive(2'b11, 6'd0, 6'b001011, 1'b1, 1'b1, 32'h1, 32'h0, 32'hFFFFFFFF);
      check("sltiu", result, 32'h1);
      drive(2'b11, 6'd0, 6'b001010, 1'b0, 1'b1, 32'h1, 32'h0, 32'hFFFFFFFF);
      check("slti", result, 32'h0);

      // REGIMM forces B to zero regardless of imm
      drive(2'b01, 6'd0, 6'b000001, 1'b0, 1'b1, 32'hFFFFFFF0, 32'h0, 32'h1234);
      check("bgez_lt", {31'h0, lt}, 32'h1);
      check("bgez_eq", {31'h0, eq}, 32'h0);
      check("bgez_res", result, 32'hFFFFFFF0);

      drive(2'b01, 6'd0, 6'b000100, 1'b0, 1'b0, 32'h5, 32'h5, 32'h0);
      check("beq_eq", {31'h0, eq}, 32'h1);
      check("beq_res", result, 32'h0);

      drive(2'b10, 6'b000011, 6'd0, 1'b0, 1'b0, 32'h4, 32'h80000000, 32'h0);
      check("sra", result, 32'hF8000000);
      drive(2'b10, 6'b000010, 6'd0, 1'b0, 1'b0, 32'h4, 32'h80000000, 32'h0);
      check("srl", result, 32'h08000000);
      drive(2'b10, 6'b000100, 6'd0, 1'b0, 1'b0, 32'h24, 32'h1, 32'h0);
      check("sllv", result, 32'h10);

      drive(2'b11, 6'd0, 6'b001111, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000ABCD);
      check("lui", result, 32'hABCD0000);

      drive(2'b10, 6'b100100, 6'd0, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);
      check("and", result, 32'hF000F000);
      drive(2'b10, 6'b100101, 6'd0, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);
      check("or", result, 32'hFFF0FFF0);
      drive(2'b10, 6'b100110, 6'd0, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);
      check("xor", result, 32'h0FF00FF0);
      drive(2'b10, 6'b100111, 6'd0, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);
      check("nor", result, 32'h000F000F);
      drive(2'b10, 6'b100011, 6'd0, 1'b0, 1'b0, 32'h3, 32'h5, 32'h0);
      check("subu", result, 32'hFFFFFFFE);
      drive(2'b10, 6'b001000, 6'd0, 1'b0, 1'b0, 32'h3, 32'h4, 32'h0);
      check("jr_add", result, 32'h7);
      drive(2'b00, 6'd0, 6'b100011, 1'b0, 1'b1, 32'h100, 32'h0, 32'hFFFFFFFC);
      check("lw_add", result, 32'hFC);

      drive(2'b10, 6'b011000, 6'd0, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h3, 32'h0);
      check("mult_res", result, 32'h0);
      tick();
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFFA);

      drive(2'b10, 6'b011001, 6'd0, 1'b1, 1'b0, 32'hFFFFFFFE, 32'h3, 32'h0);
      tick();
      check("multu_hi", hi, 32'h2);
      check("multu_lo", lo, 32'hFFFFFFFA);

      drive(2'b10, 6'b011011, 6'd0, 1'b1, 1'b0, 32'h7, 32'h2, 32'h0);
      tick();
      check("divu_hi", hi, 32'h1);
      check("divu_lo", lo, 32'h3);

      drive(2'b10, 6'b011010, 6'd0, 1'b0, 1'b0, 32'hFFFFFFF9, 32'h2, 32'h0);
      tick();
      check("div_hi", hi, 32'hFFFFFFFF);
      check("div_lo", lo, 32'hFFFFFFFD);

      drive(2'b10, 6'b011010, 6'd0, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h0);
      tick();
      check("div0_hi", hi, 32'hFFFFFFFF);
      check("div0_lo", lo, 32'hFFFFFFFD);

      drive(2'b10, 6'b011010, 6'd0, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0);
      tick();
      check("divov_hi", hi, 32'h0);
      check("divov_lo", lo, 32'h80000000);

      // Reset must clear HI/LO even with the clock enable low
      drive(2'b10, 6'b011000, 6'd0, 1'b0, 1'b0, 32'h3, 32'h3, 32'h0);
      reset = 1'b1;
      clk_enable = 1'b0;
      tick();
      check("rst2_hi", hi, 32'h0);
      check("rst2_lo", lo, 32'h0);
      reset = 1'b0;

      drive(2'b10, 6'b010011, 6'd0, 1'b0, 1'b0, 32'h55, 32'h0, 32'h0);
      tick();
      check("mtlo_hold", lo, 32'h0);
      clk_enable = 1'b1;
      tick();
      check("mtlo", lo, 32'h55);
      drive(2'b10, 6'b010001, 6'd0, 1'b0, 1'b0, 32'hAA, 32'h0, 32'h0);
      tick();
      check("mthi", hi, 32'hAA);
      check("mthi_lo", lo, 32'h55);

      clk_enable = 1'b0;
      drive(2'b10, 6'b011000, 6'd0, 1'b0, 1'b0, 32'h10, 32'h10, 32'h0);
      tick();
      check("en0_hi", hi, 32'hAA);
      check("en0_lo", lo, 32'h55);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_cpu_exec_unit.md
Name: mips_cpu_exec_unit

Overview:
- Execute stage of the single-cycle Harvard MIPS CPU: ALU-control decode, branch-operand selection, 32-bit ALU with eq/lt flags, and the architectural HI/LO registers.
- Sits between register file/control unit and the data-memory/write-back muxes.
- Result and flags are combinational; HI/LO update on the clock edge.

Parameters:
- None. Datapath is fixed at 32 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_enable  in  1  global clock enable; HI/LO update only when high
- insop  in  6  instruction opcode [31:26]
- func  in  6  instruction function field [5:0]
- aluop  in  2  from control: 00 add, 01 compare/sub (branches), 10 R-type (decode func), 11 I-type (decode insop)
- unsign  in  1  1 = unsigned compare / multiply / divide
- alusrc  in  1  0 = B operand is rt_data; 1 = B operand is branch-data output
- alu_a  in  32  A operand: rs, or zero-extended sa for immediate shifts (selected outside)
- rt_data  in  32  rt register value
- imm  in  32  already-extended immediate
- result  out  32  ALU result
- eq  out  1  alu_a == B
- lt  out  1  alu_a < B, signed or unsigned per unsign
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Branch data: B_imm = 0 when insop is 000001 (REGIMM), 000110 (BLEZ) or 000111 (BGTZ); otherwise B_imm = imm.
- B = alusrc ? B_imm : rt_data.
- Internal 4-bit alucon codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB, 0111 SLT, 1000 SLL, 1001 SRL, 1010 SRA, 1011 MULT, 1100 DIV, 1101 LUI, 1110 MTHI, 1111 MTLO.
- aluop 00 -> ADD; aluop 01 -> SUB.
- aluop 10, func decode:
  - 100000/100001 ADD; 100010/100011 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010/101011 SLT.
  - 000000/000100 SLL; 000010/000110 SRL; 000011/000111 SRA.
  - 011000/011001 MULT; 011010/011011 DIV; 010001 MTHI; 010011 MTLO.
  - Any other func (JR, JALR, MFHI, MFLO) -> ADD.
- aluop 11, insop decode: 001000/001001 ADD; 001010/001011 SLT; 001100 AND; 001101 OR; 001110 XOR; 001111 LUI; other -> ADD.
- Arithmetic:
  - ADD/SUB wrap modulo 2^32; no overflow trap.
  - SLT result = {31'b0, lt}.
  - Shifts: result = B shifted by alu_a[4:0]; SRA sign-fills from B[31].
  - LUI result = {B[15:0], 16'h0}.
  - MULT/DIV/MTHI/MTLO: result = 0.
- eq and lt are computed for every code. unsign is 0 for branch opcodes, so branch lt is signed.
- MULT: 64-bit product of alu_a and B, signed or unsigned per unsign; HI = upper word, LO = lower word.
- DIV: LO = quotient (truncated toward zero), HI = remainder (takes the dividend's sign); signed or unsigned per unsign.
  - Signed 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
  - B == 0: HI/LO unchanged.
- HI/LO register write rules:
  - reset high at posedge -> HI = LO = 0, regardless of clk_enable.
  - Otherwise, at posedge with clk_enable = 1: MULT/DIV write both; MTHI writes HI = alu_a; MTLO writes LO = alu_a.
  - Otherwise hold.
  - New values visible one cycle after the instruction.
- No other state; result, eq and lt are purely combinational with zero latency.

Decomposition:
- Shared package mips_cpu_pkg: ALUOP_* constants, alucon enum, opcode and func constants.
- One natural sub-module: mips_cpu_exec_alu_decode (aluop/func/insop -> alucon).
- Branch-data mux, ALU and HI/LO registers live in the top.

Test Plan:
- R-type ADDU: aluop 10, func 100001, a = 0x7FFFFFFF, rt = 1, alusrc 0 -> result 0x80000000, eq 0.
- I-type SLTIU vs SLTI: aluop 11, alusrc 1, imm 0xFFFFFFFF, a = 1, insop 001011 with unsign 1 -> result 1; insop 001010 with unsign 0 -> result 0.
- BGEZ operand: aluop 01, insop 000001, alusrc 1, imm 0x1234, a = 0xFFFFFFF0 -> B = 0, lt 1, eq 0.
- Shifts: SRA with a = 4, rt = 0x80000000 -> 0xF8000000; LUI with imm 0x0000ABCD -> 0xABCD0000.
- MULT/DIV then reset:
  - MULT signed 0xFFFFFFFE × 3 -> next cycle HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - DIVU 7/2 -> HI = 1, LO = 3.
  - DIV by 0 -> unchanged.
  - Reset -> both 0.
- clk_enable = 0 during MTLO 0x55 -> LO holds; with clk_enable = 1 -> LO = 0x55 next cycle.
